ps2_key_decoder: RTL

- Receives PS/2 keyboard frames and decodes scan-code set 2 make/break sequences.
- Emits single-cycle key-event strobes on the system clock, including the one-cycle `enter` pulse that drives the start-screen and game-control FSMs.
- Sits between the board PS/2 pins and all game logic that consumes keystrokes.

---
 rtl/ps2_key_decoder_pkg.sv | 28 ++
 rtl/ps2_key_decoder_frame_rx.sv | 140 ++++++++++++++
 rtl/ps2_key_decoder.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared scan-code constants and FSM state encodings for the PS/2 keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    SEQ_BASE,
    SEQ_EXT,
    SEQ_BRK,
    SEQ_EXT_BRK
  } seq_state_e;

endpackage

// File: rtl/ps2_key_decoder_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge sampling, 11-bit frame FSM, timeout.
// Odd-parity checking is compiled in when PS2_PARITY_CHECK_EN is defined.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_rdy,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   byte_rdy_q, byte_rdy_d;
  logic                   frame_err_q, frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
  logic                   par_q, par_d;
`endif

  logic fall;
  logic sdata;
  logic timeout;
  logic par_ok;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    fall        = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    sdata       = data_sync_q[SYNC_STAGES-1];
  end

  // The edge always wins over an expiring timeout, so a late edge still counts.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (fall || state_q == RX_IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
    timeout = (state_q != RX_IDLE) && (to_cnt_q == TO_MAX) && !fall;
  end

`ifdef PS2_PARITY_CHECK_EN
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_rdy_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d       = par_q;
`endif
    if (timeout) begin
      state_d   = RX_IDLE;
      bit_cnt_d = '0;
    end else if (fall) begin
      unique case (state_q)
        RX_IDLE: begin
          if (!sdata) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {sdata, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = sdata;
`endif
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (sdata && par_ok) byte_rdy_d = 1'b1;
          else                 frame_err_d = 1'b1;
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  // Synchronizers reset to the idle-high bus level to avoid a false edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      state_q     <= RX_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      to_cnt_q    <= '0;
      byte_rdy_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= 1'b0;
`endif
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      to_cnt_q    <= to_cnt_d;
      byte_rdy_q  <= byte_rdy_d;
      frame_err_q <= frame_err_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q       <= par_d;
`endif
    end
  end

  assign byte_rdy  = byte_rdy_q;
  assign rx_byte   = shift_q;
  assign frame_err = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 decoder: make/break/extended sequencing plus a held-Enter filter.
// Optional odd-parity checking in the frame receiver via PS2_PARITY_CHECK_EN.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       enter,
  output logic       frame_err
);

  logic       byte_rdy;
  logic [7:0] rx_byte;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_frame_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .byte_rdy (byte_rdy),
    .rx_byte  (rx_byte),
    .frame_err(frame_err)
  );

  seq_state_e seq_q, seq_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_break_q, key_break_d;
  logic       enter_q, enter_d;
  logic       enter_held_q, enter_held_d;
  logic       ev, ev_ext, ev_brk;

  always_comb begin
    seq_d  = seq_q;
    ev     = 1'b0;
    ev_ext = 1'b0;
    ev_brk = 1'b0;
    if (byte_rdy) begin
      if (rx_byte == SC_PAUSE) begin
        seq_d = SEQ_BASE;
      end else begin
        unique case (seq_q)
          SEQ_BASE: begin
            if (rx_byte == SC_EXT)        seq_d = SEQ_EXT;
            else if (rx_byte == SC_BREAK) seq_d = SEQ_BRK;
            else                          ev    = 1'b1;
          end
          SEQ_EXT: begin
            if (rx_byte == SC_BREAK) begin
              seq_d = SEQ_EXT_BRK;
            end else begin
              ev     = 1'b1;
              ev_ext = 1'b1;
              seq_d  = SEQ_BASE;
            end
          end
          SEQ_BRK: begin
            ev     = 1'b1;
            ev_brk = 1'b1;
            seq_d  = SEQ_BASE;
          end
          SEQ_EXT_BRK: begin
            ev     = 1'b1;
            ev_ext = 1'b1;
            ev_brk = 1'b1;
            seq_d  = SEQ_BASE;
          end
          default: seq_d = SEQ_BASE;
        endcase
      end
    end
  end

  // Only the main-block Enter participates in the held filter; keypad Enter is ignored.
  always_comb begin
    key_valid_d  = 1'b0;
    key_code_d   = key_code_q;
    key_ext_d    = key_ext_q;
    key_break_d  = key_break_q;
    enter_d      = 1'b0;
    enter_held_d = enter_held_q;
    if (ev) begin
      key_valid_d = 1'b1;
      key_code_d  = rx_byte;
      key_ext_d   = ev_ext;
      key_break_d = ev_brk;
      if (rx_byte == SC_ENTER && !ev_ext) begin
        if (ev_brk) begin
          enter_held_d = 1'b0;
        end else begin
          enter_held_d = 1'b1;
          enter_d      = !enter_held_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_q        <= SEQ_BASE;
      key_valid_q  <= 1'b0;
      key_code_q   <= '0;
      key_ext_q    <= 1'b0;
      key_break_q  <= 1'b0;
      enter_q      <= 1'b0;
      enter_held_q <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      key_valid_q  <= key_valid_d;
      key_code_q   <= key_code_d;
      key_ext_q    <= key_ext_d;
      key_break_q  <= key_break_d;
      enter_q      <= enter_d;
      enter_held_q <= enter_held_d;
    end
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign enter     = enter_q;

endmodule
